// File: rtl/bullet_scheduler_pkg.sv
// Shared constants and types for the bullet scheduler and the sprite and
// collision blocks that consume its per-slot positions.
package bullet_scheduler_pkg;

  localparam int CORDW         = 10;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_PLAYER_Y  = 440;
  localparam int DEF_P_SPEED   = 4;
  localparam int DEF_A_SPEED   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/bullet_scheduler_rr_free_slot_picker.sv
// Combinational round-robin search for the first free alien slot, starting at
// ptr and wrapping within 1..NUM_SLOTS-1 (slot 0 belongs to the player).
module rr_free_slot_picker #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] active,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     slot
);

  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found    = 1'b0;
    slot     = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_SLOTS - 1; k++) begin
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_SLOTS)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_SLOTS - 1);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!found && !active[cand]) begin
        found = 1'b1;
        slot  = cand;
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Per-frame bullet update: moves and retires every slot one per cycle, then
// spawns player/alien bullets from latched fire requests.
module bullet_scheduler
  import bullet_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int P_SPEED   = DEF_P_SPEED,
  parameter int A_SPEED   = DEF_A_SPEED,
  parameter int PLAYER_Y  = DEF_PLAYER_Y,
  parameter int SCREEN_H  = DEF_SCREEN_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       fire_player,
  input  logic [CORDW-1:0]           player_x,
  input  logic                       fire_alien,
  input  logic [CORDW-1:0]           alien_x,
  input  logic [CORDW-1:0]           alien_y,
  input  logic [NUM_SLOTS-1:0]       kill,
  output logic [CORDW*NUM_SLOTS-1:0] bullet_x,
  output logic [CORDW*NUM_SLOTS-1:0] bullet_y,
  output logic [NUM_SLOTS-1:0]       active,
  output logic                       busy,
  output logic                       fire_ack_p,
  output logic                       fire_ack_a
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [CORDW-1:0] P_STEP  = CORDW'(P_SPEED);
  localparam logic [CORDW-1:0] Y_SPAWN = CORDW'(PLAYER_Y);
  localparam logic [CORDW:0]   A_STEP  = (CORDW+1)'(A_SPEED);
  localparam logic [CORDW:0]   Y_LIMIT = (CORDW+1)'(SCREEN_H);

  sched_state_e               state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           rr_q, rr_d;
  logic [CORDW*NUM_SLOTS-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_SLOTS-1:0]       active_q, active_d;
  logic                       pend_p_q, pend_p_d;
  logic                       pend_a_q, pend_a_d;
  logic [CORDW-1:0]           cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic                       ack_p_q, ack_p_d, ack_a_q, ack_a_d;

  logic [CORDW-1:0]           cur_y;
  logic [CORDW:0]             sum_y;
  logic                       pick_found;
  logic [IDX_W-1:0]           pick_slot;

  // Slots being killed this cycle look occupied so no spawn lands in them.
  rr_free_slot_picker #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .active(active_q | kill),
    .ptr   (rr_q),
    .found (pick_found),
    .slot  (pick_slot)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    pend_p_d = pend_p_q;
    pend_a_d = pend_a_q;
    cap_x_d  = cap_x_q;
    cap_y_d  = cap_y_q;
    ack_p_d  = 1'b0;
    ack_a_d  = 1'b0;
    cur_y    = '0;
    sum_y    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_MOVE;
          idx_d   = '0;
        end
      end

      S_MOVE: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (idx_q == IDX_W'(i) && active_q[i] && !kill[i]) begin
            cur_y = y_q[i*CORDW +: CORDW];
            if (i == 0) begin
              if (cur_y < P_STEP) active_d[i] = 1'b0;
              else                y_d[i*CORDW +: CORDW] = cur_y - P_STEP;
            end else begin
              // Eleven-bit sum so a bullet near the bottom cannot wrap to the top.
              sum_y = {1'b0, cur_y} + A_STEP;
              if (sum_y >= Y_LIMIT) active_d[i] = 1'b0;
              else                  y_d[i*CORDW +: CORDW] = sum_y[CORDW-1:0];
            end
          end
        end
        if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = S_SPAWN;
        else                                idx_d   = idx_q + IDX_W'(1);
      end

      S_SPAWN: begin
        if (pend_p_q && !active_q[0] && !kill[0]) begin
          x_d[0 +: CORDW] = player_x;
          y_d[0 +: CORDW] = Y_SPAWN;
          active_d[0]     = 1'b1;
          ack_p_d         = 1'b1;
        end
        if (pend_a_q && pick_found) begin
          for (int i = 1; i < NUM_SLOTS; i++) begin
            if (pick_slot == IDX_W'(i)) begin
              x_d[i*CORDW +: CORDW] = cap_x_q;
              y_d[i*CORDW +: CORDW] = cap_y_q;
              active_d[i]           = 1'b1;
            end
          end
          ack_a_d = 1'b1;
          rr_d    = (pick_slot == IDX_W'(NUM_SLOTS - 1)) ? IDX_W'(1)
                                                         : pick_slot + IDX_W'(1);
        end
        state_d = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    active_d = active_d & ~kill;

    // Requests seen during SPAWN belong to the next frame.
    if (state_q == S_SPAWN) begin
      pend_p_d = fire_player;
      pend_a_d = fire_alien;
      if (fire_alien) begin
        cap_x_d = alien_x;
        cap_y_d = alien_y;
      end
    end else begin
      if (fire_player) pend_p_d = 1'b1;
      if (fire_alien && !pend_a_q) begin
        pend_a_d = 1'b1;
        cap_x_d  = alien_x;
        cap_y_d  = alien_y;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rr_q     <= IDX_W'(1);
      x_q      <= '0;
      y_q      <= '0;
      active_q <= '0;
      pend_p_q <= 1'b0;
      pend_a_q <= 1'b0;
      cap_x_q  <= '0;
      cap_y_q  <= '0;
      ack_p_q  <= 1'b0;
      ack_a_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      pend_p_q <= pend_p_d;
      pend_a_q <= pend_a_d;
      cap_x_q  <= cap_x_d;
      cap_y_q  <= cap_y_d;
      ack_p_q  <= ack_p_d;
      ack_a_q  <= ack_a_d;
    end
  end

  assign bullet_x   = x_q;
  assign bullet_y   = y_q;
  assign active     = active_q;
  assign busy       = (state_q != S_IDLE);
  assign fire_ack_p = ack_p_q;
  assign fire_ack_a = ack_a_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Frame-level scoreboard bench for bullet_scheduler: a behavioural model
// predicts each frame's result, which is compared once the pass completes.
module tb_bullet_scheduler;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic            fire_player;
  logic [9:0]      player_x;
  logic            fire_alien;
  logic [9:0]      alien_x;
  logic [9:0]      alien_y;
  logic [NS-1:0]   kill;
  logic [10*NS-1:0] bullet_x;
  logic [10*NS-1:0] bullet_y;
  logic [NS-1:0]   active;
  logic            busy;
  logic            fire_ack_p;
  logic            fire_ack_a;

  always #5 clk = ~clk;

  bullet_scheduler #(.NUM_SLOTS(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .fire_player(fire_player),
    .player_x   (player_x),
    .fire_alien (fire_alien),
    .alien_x    (alien_x),
    .alien_y    (alien_y),
    .kill       (kill),
    .bullet_x   (bullet_x),
    .bullet_y   (bullet_y),
    .active     (active),
    .busy       (busy),
    .fire_ack_p (fire_ack_p),
    .fire_ack_a (fire_ack_a)
  );

  typedef struct {
    logic [NS-1:0]    act;
    logic [10*NS-1:0] bx;
    logic [10*NS-1:0] by;
    int               ackp;
    int               acka;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_act[NS];
  int m_x[NS];
  int m_y[NS];
  int m_rr, m_pend_p, m_pend_a, m_cap_x, m_cap_y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_rr = 1; m_pend_p = 0; m_pend_a = 0; m_cap_x = 0; m_cap_y = 0;
  endtask

  function automatic int any_active();
    int r = 0;
    for (int i = 0; i < NS; i++) r = r | m_act[i];
    return r;
  endfunction

  task automatic model_latch(input int fp, input int fa, input int ax, input int ay);
    if (fp != 0) m_pend_p = 1;
    if (fa != 0 && m_pend_a == 0) begin
      m_pend_a = 1; m_cap_x = ax; m_cap_y = ay;
    end
  endtask

  task automatic model_frame(input int px, input int kslot, input int late_fp, output exp_t e);
    int s;
    e.ackp = 0; e.acka = 0;
    for (int i = 0; i < NS; i++) begin
      if (i == kslot) m_act[i] = 0;
      else if (m_act[i] != 0) begin
        if (i == 0) begin
          if (m_y[0] < 4) m_act[0] = 0; else m_y[0] = m_y[0] - 4;
        end else begin
          if (m_y[i] + 2 >= 480) m_act[i] = 0; else m_y[i] = m_y[i] + 2;
        end
      end
    end
    if (m_pend_p != 0 && m_act[0] == 0) begin
      m_act[0] = 1; m_x[0] = px; m_y[0] = 440; e.ackp = 1;
    end
    m_pend_p = late_fp;
    if (m_pend_a != 0) begin
      for (int k = 0; k < NS - 1; k++) begin
        s = ((m_rr - 1 + k) % (NS - 1)) + 1;
        if (e.acka == 0 && m_act[s] == 0) begin
          m_act[s] = 1; m_x[s] = m_cap_x; m_y[s] = m_cap_y; e.acka = 1;
          m_rr = (s == NS - 1) ? 1 : s + 1;
        end
      end
    end
    m_pend_a = 0;
    for (int i = 0; i < NS; i++) begin
      e.act[i]        = (m_act[i] != 0);
      e.bx[i*10 +: 10] = 10'(m_x[i]);
      e.by[i*10 +: 10] = 10'(m_y[i]);
    end
  endtask

  // One request cycle, then a full frame pass; kslot kills that slot during
  // its MOVE cycle, late_fp fires the player during the SPAWN cycle.
  task automatic run_frame(input int fp, input int px, input int fa, input int ax,
                           input int ay, input int kslot, input int late_fp);
    exp_t e;
    int busy_cnt = 0;
    int ackp_cnt = 0;
    int acka_cnt = 0;
    int cyc = 0;
    fire_player = (fp != 0);
    player_x    = 10'(px);
    fire_alien  = (fa != 0);
    alien_x     = 10'(ax);
    alien_y     = 10'(ay);
    model_latch(fp, fa, ax, ay);
    @(negedge clk);
    fire_player = 1'b0;
    fire_alien  = 1'b0;
    frame_tick  = 1'b1;
    model_frame(px, kslot, late_fp, e);
    sb.push_back(e);
    do begin
      @(negedge clk);
      frame_tick = 1'b0;
      cyc++;
      if (busy)       busy_cnt++;
      if (fire_ack_p) ackp_cnt++;
      if (fire_ack_a) acka_cnt++;
      kill        = (kslot >= 0 && cyc == kslot + 1) ? NS'(1 << kslot) : '0;
      fire_player = (late_fp != 0 && cyc == NS + 1);
    end while (busy && cyc < 30);
    kill        = '0;
    fire_player = 1'b0;
    check("busy_timeout", 64'(busy), 64'(0));
    check("busy_cycles", 64'(busy_cnt), 64'(NS + 2));
    e = sb.pop_front();
    check("active",   64'(active),   64'(e.act));
    check("bullet_x", 64'(bullet_x), 64'(e.bx));
    check("bullet_y", 64'(bullet_y), 64'(e.by));
    check("ack_p",    64'(ackp_cnt), 64'(e.ackp));
    check("ack_a",    64'(acka_cnt), 64'(e.acka));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 64'(active),     64'(0));
    check({tag, "_x"},      64'(bullet_x),   64'(0));
    check({tag, "_y"},      64'(bullet_y),   64'(0));
    check({tag, "_busy"},   64'(busy),       64'(0));
    check({tag, "_ackp"},   64'(fire_ack_p), 64'(0));
    check({tag, "_acka"},   64'(fire_ack_a), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b1; frame_tick = 1'b0; fire_player = 1'b0; fire_alien = 1'b0;
    player_x = '0; alien_x = '0; alien_y = '0; kill = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 0, 0, 0, 0, -1, 0);      // empty frame
    run_frame(1, 100, 0, 0, 0, -1, 0);    // player spawn at 100/440
    run_frame(0, 0, 0, 0, 0, -1, 0);      // 436
    run_frame(1, 200, 0, 0, 0, -1, 0);    // fire while in flight: dropped
    run_frame(0, 0, 0, 0, 0, -1, 0);      // not kept

    run_frame(0, 0, 1, 10, 50, -1, 0);    // slot 1
    run_frame(0, 0, 1, 20, 50, -1, 0);    // slot 2
    run_frame(0, 0, 1, 30, 50, -1, 0);    // slot 3
    run_frame(0, 0, 1, 40, 50, -1, 0);    // all busy: no ack

    guard = 0;
    while (any_active() != 0 && guard < 300) begin
      run_frame(0, 0, 0, 0, 0, -1, 0);
      guard++;
    end
    check("retire_all", 64'(active), 64'(0));

    run_frame(0, 0, 0, 0, 0, -1, 1);      // fire during SPAWN
    run_frame(0, 321, 0, 0, 0, -1, 0);    // spawns from the late request

    run_frame(0, 0, 1, 77, 200, -1, 0);   // alien at 200
    run_frame(0, 0, 0, 0, 0, -1, 0);      // 202
    run_frame(0, 0, 1, 5, 476, -1, 0);    // alien at 476
    run_frame(0, 0, 0, 0, 0, -1, 0);      // 478
    run_frame(0, 0, 0, 0, 0, -1, 0);      // 478+2 >= 480: retired
    run_frame(0, 0, 1, 60, 100, -1, 0);
    run_frame(0, 0, 1, 70, 120, -1, 0);
    run_frame(0, 0, 0, 0, 0, 2, 0);       // kill slot 2 in its MOVE cycle

    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    run_frame(0, 0, 0, 0, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
